// File: rtl/sub_fx_pipe.sv
// sub_fx_pipe: two-stage signed fixed-point subtractor with valid/ready flow
// control. Stage 1 captures the exact difference. Stage 2 rounds half toward
// +inf, saturates to the narrower output format and holds the output sample.
// A sticky counter tracks how many saturated samples entered stage 2.
module sub_fx_pipe #(
    parameter int W_IN     = 13,
    parameter int FRAC_IN  = 8,
    parameter int W_OUT    = 12,
    parameter int FRAC_OUT = 7,
    parameter int CNT_W    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic signed [W_IN-1:0]  i_data_1,
    input  logic signed [W_IN-1:0]  i_data_2,
    input  logic                    i_valid,
    output logic                    i_ready,
    output logic signed [W_OUT-1:0] o_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic                    o_sat,
    input  logic                    i_clr,
    output logic [CNT_W-1:0]        o_sat_cnt
);

    localparam int D  = FRAC_IN - FRAC_OUT;
    localparam int WD = W_IN + 1;   // exact difference width
    localparam int WR = W_IN + 2;   // headroom for the rounding carry

    localparam logic signed [WR-1:0] SAT_MAX = WR'((32'sd1 <<< (W_OUT - 1)) - 32'sd1);
    localparam logic signed [WR-1:0] SAT_MIN = WR'(-(32'sd1 <<< (W_OUT - 1)));

    logic signed [WD-1:0]    diff_s;
    logic signed [WD-1:0]    diff_r;
    logic signed [WR-1:0]    rnd_s;
    logic signed [W_OUT-1:0] sat_data_s;
    logic                    sat_flag_s;
    logic                    v1_r;
    logic                    v2_r;
    logic signed [W_OUT-1:0] data_r;
    logic                    sat_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    in_xfer_s;
    logic                    load2_s;
    logic                    out_xfer_s;

    // Flow control: a full pipeline still accepts when the output drains now.
    assign i_ready    = ~v1_r | ~v2_r | o_ready;
    assign in_xfer_s  = i_valid & i_ready;
    assign load2_s    = v1_r & (~v2_r | o_ready);
    assign out_xfer_s = v2_r & o_ready;

    assign diff_s = $signed({i_data_1[W_IN-1], i_data_1})
                  - $signed({i_data_2[W_IN-1], i_data_2});

    assign o_data    = data_r;
    assign o_valid   = v2_r;
    assign o_sat     = sat_r;
    assign o_sat_cnt = cnt_r;

    generate
        if (D > 0) begin : g_round
            localparam logic signed [WR-1:0] HALF = WR'(32'sd1 <<< (D - 1));
            // Add half an output LSB, then drop D fraction bits (round half up).
            always_comb begin
                rnd_s = ($signed({diff_r[WD-1], diff_r}) + HALF) >>> D;
            end
        end else begin : g_pass
            // Same fraction width: the difference passes through unrounded.
            always_comb begin
                rnd_s = $signed({diff_r[WD-1], diff_r});
            end
        end
    endgenerate

    // Clamp the rounded value into the output range and flag any clamping.
    always_comb begin
        sat_data_s = rnd_s[W_OUT-1:0];
        sat_flag_s = 1'b0;
        if (rnd_s > SAT_MAX) begin
            sat_data_s = SAT_MAX[W_OUT-1:0];
            sat_flag_s = 1'b1;
        end else if (rnd_s < SAT_MIN) begin
            sat_data_s = SAT_MIN[W_OUT-1:0];
            sat_flag_s = 1'b1;
        end else begin
            sat_data_s = rnd_s[W_OUT-1:0];
            sat_flag_s = 1'b0;
        end
    end

    // Stage 1: capture the exact difference on each input transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_r   <= 1'b0;
            diff_r <= '0;
        end else if (in_xfer_s) begin
            v1_r   <= 1'b1;
            diff_r <= diff_s;
        end else if (load2_s) begin
            v1_r   <= 1'b0;
        end else begin
            v1_r   <= v1_r;
        end
    end

    // Stage 2: output register, reloaded only when stage 1 can advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v2_r   <= 1'b0;
            data_r <= '0;
            sat_r  <= 1'b0;
        end else if (load2_s) begin
            v2_r   <= 1'b1;
            data_r <= sat_data_s;
            sat_r  <= sat_flag_s;
        end else if (out_xfer_s) begin
            v2_r   <= 1'b0;
        end else begin
            v2_r   <= v2_r;
        end
    end

    // Saturation counter: one count per saturated sample entering stage 2,
    // sticky at all-ones, and clear takes priority over a coincident count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= '0;
        end else if (i_clr) begin
            cnt_r <= '0;
        end else if (load2_s && sat_flag_s && !(&cnt_r)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_sub_fx_pipe.sv
// Directed and random bench for sub_fx_pipe with a scoreboard of
// subtract -> round half up -> saturate results checked in order.
module tb_sub_fx_pipe;

    logic               clk;
    logic               rst_n;
    logic signed [12:0] d1;
    logic signed [12:0] d2;
    logic               i_valid;
    logic               i_ready;
    logic signed [11:0] o_data;
    logic               o_valid;
    logic               o_ready;
    logic               o_sat;
    logic               i_clr;
    logic [15:0]        o_sat_cnt;

    int checks;
    int errors;
    int popped;
    int exp_q[$];
    bit sat_q[$];
    bit stall_prev;
    logic signed [11:0] held_data;
    logic               held_sat;

    sub_fx_pipe dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_data_1  (d1),
        .i_data_2  (d2),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_sat     (o_sat),
        .i_clr     (i_clr),
        .o_sat_cnt (o_sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: Q.8 - Q.8, round half toward +inf to Q.7, clamp to 12 bits.
    function automatic void model(input int a, input int b, output int r, output bit s);
        int diff;
        diff = a - b;
        r = (diff + 1) >>> 1;
        s = 1'b0;
        if (r > 2047) begin
            r = 2047;
            s = 1'b1;
        end else if (r < -2048) begin
            r = -2048;
            s = 1'b1;
        end
    endfunction

    // One clock: at the falling edge observe transfers that the next rising
    // edge will perform, then return just after that rising edge.
    task automatic tick();
        int r;
        bit s;
        @(negedge clk);
        if (rst_n) begin
            if (stall_prev) begin
                chk("stall_valid", o_valid, 1);
                chk("stall_data", o_data, held_data);
                chk("stall_sat", o_sat, held_sat);
            end
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    chk("out_data", o_data, exp_q.pop_front());
                    chk("out_sat", o_sat, sat_q.pop_front());
                    popped++;
                end
            end
            if (i_valid && i_ready) begin
                model(int'(d1), int'(d2), r, s);
                exp_q.push_back(r);
                sat_q.push_back(s);
            end
            stall_prev = o_valid && !o_ready;
            held_data  = o_data;
            held_sat   = o_sat;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Single sample with o_ready high: checks the two-cycle latency directly.
    task automatic send_one(input int a, input int b, input int exp, input bit esat,
                            input string tag);
        d1 = 13'(a);
        d2 = 13'(b);
        i_valid = 1'b1;
        o_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, i_ready, 1);
        tick();
        i_valid = 1'b0;
        chk({tag, "_v_k1"}, o_valid, 0);
        tick();
        chk({tag, "_v_k2"}, o_valid, 1);
        chk({tag, "_data"}, o_data, exp);
        chk({tag, "_sat"}, o_sat, esat);
        tick();
        chk({tag, "_drained"}, o_valid, 0);
    endtask

    initial begin
        int idx;
        int c;
        int base;
        bit acc;
        checks = 0;
        errors = 0;
        popped = 0;
        stall_prev = 1'b0;
        held_data = '0;
        held_sat = 1'b0;
        rst_n = 1'b0;
        d1 = '0;
        d2 = '0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        i_clr = 1'b0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_sat", o_sat, 0);
        chk("rst_cnt", o_sat_cnt, 0);
        chk("rst_ready", i_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic and rounding cases.
        send_one(300, 100, 100, 1'b0, "b300_100");
        send_one(301, 100, 101, 1'b0, "b301_100");
        send_one(-3, 0, -1, 1'b0, "bm3_0");

        // Saturation at both rails.
        send_one(4095, -4096, 2047, 1'b1, "sat_pos");
        send_one(-4096, 4095, -2048, 1'b1, "sat_neg");
        chk("sat_cnt2", o_sat_cnt, 2);

        // Backpressure: 10 back-to-back samples, o_ready low in cycles 3..7.
        base = popped;
        idx = 0;
        c = 0;
        while ((idx < 10 || exp_q.size() != 0 || o_valid) && c < 40) begin
            i_valid = (idx < 10);
            d1 = 13'(idx * 37 - 100);
            d2 = 13'(idx * 11);
            o_ready = !(c >= 3 && c <= 7);
            #1;
            if (c == 3) chk("bp_ready_c3", i_ready, 0);
            if (c == 7) chk("bp_ready_c7", i_ready, 0);
            if (c == 8) chk("bp_ready_c8", i_ready, 1);
            acc = i_valid && i_ready;
            tick();
            if (acc) idx++;
            c++;
        end
        i_valid = 1'b0;
        chk("bp_accepted", idx, 10);
        chk("bp_emerged", popped - base, 10);

        // Counter sticks at all-ones.
        for (int n = 0; n < 65537; n++) begin
            d1 = n[0] ? -13'sd4096 : 13'sd4095;
            d2 = n[0] ? 13'sd4095 : -13'sd4096;
            i_valid = 1'b1;
            o_ready = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        tick();
        tick();
        chk("cnt_sticky", o_sat_cnt, 65535);

        // Clear coinciding with a saturated load wins.
        d1 = 13'sd4095;
        d2 = -13'sd4096;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        chk("clr_cnt", o_sat_cnt, 0);
        chk("clr_sat", o_sat, 1);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        chk("cnt_after_clr", o_sat_cnt, 1);
        tick();

        // Reset with both stages full.
        o_ready = 1'b0;
        d1 = -13'sd4096;
        d2 = 13'sd4095;
        i_valid = 1'b1;
        tick();
        tick();
        i_valid = 1'b0;
        #1;
        chk("full_valid", o_valid, 1);
        chk("full_ready", i_ready, 0);
        chk("full_cnt", o_sat_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_cnt", o_sat_cnt, 0);
        chk("mid_rst_ready", i_ready, 1);
        chk("mid_rst_data", o_data, 0);
        exp_q.delete();
        sat_q.delete();
        tick();
        rst_n = 1'b1;
        send_one(300, 100, 100, 1'b0, "post_rst");

        // Random operands with random backpressure.
        for (int n = 0; n < 2000; n++) begin
            i_valid = 1'($urandom_range(0, 1));
            d1 = 13'($urandom);
            d2 = 13'($urandom);
            o_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_valid", o_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
